// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg -- shared definitions for the instruction-fetch slice.
//   if_state_e        : fetch FSM states (FETCH, WAIT, HOLD)
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   PC_INC4 / PC_INC8 : sequential-fetch step and jal link offset
//   word_align()      : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding on the memory port
    WAIT  = 2'd1,  // granted, waiting for the response
    HOLD  = 2'd2   // response parked in the skid buffer, decode stalled
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_INC4          = 32'd4;
  localparam logic [31:0] PC_INC8          = 32'd8;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// -----------------------------------------------------------------------------
// if_skid_buf -- one-entry holding register for a fetched instruction that
// arrived while decode was stalled.
//   clk, reset (async, active-high)
//   load_i  : capture instr_i/pc_i and mark the entry valid
//   clear_i : drop the entry (wins over load_i)
//   valid_o, instr_o, pc_o : the held entry
// -----------------------------------------------------------------------------
module if_skid_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset too, even though valid_q qualifies it, so
      // downstream never sees X after reset in simulation.
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a single outstanding memory request,
// a skid buffer for responses that arrive while decode is stalled, and
// downstream redirect (jump/branch/jr) handling.
//   clk, reset                 : clock, async active-high reset
//   im_req/im_addr/im_gnt      : request channel to instruction memory
//   im_rvalid/im_rdata         : response channel
//   redirect_valid/redirect_pc : new fetch target, highest priority
//   id_stall                   : decode cannot accept the IF/ID slot
//   id_valid/id_instr/id_pc/id_pc8 : IF/ID slot (instruction, PC, PC+8)
//   id_exc_adel                : fetch address error (IF_ADEL_EN only)
// Build option: define IF_ADEL_EN to flag misaligned fetch PCs as address
// errors instead of silently aligning them.
// -----------------------------------------------------------------------------
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8
`ifdef IF_ADEL_EN
  ,
  output logic        id_exc_adel
`endif
);

  if_state_e   state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] req_pc_q;     // address of the request currently in flight
  logic        discard_q;    // in-flight response belongs to a flushed path
  logic        id_valid_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_pc8_q;

  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic        pc_bad;
  logic        adel_fire;
  logic [31:0] redirect_tgt;
  logic        req_fire;
  logic        rsp_live;
  logic        rsp_to_slot;
  logic        rsp_to_buf;
  logic        buf_to_slot;
  logic        buf_clear;

`ifdef IF_ADEL_EN
  localparam logic [31:0] PC_RST = RESET_PC;
  logic adel_sent_q;         // error slot already delivered, wait for redirect
  logic exc_q;

  assign pc_bad       = |fetch_pc_q[1:0];
  assign redirect_tgt = redirect_pc;
  assign adel_fire    = (state_q == FETCH) && pc_bad && !adel_sent_q
                        && !redirect_valid && !id_stall;
  assign id_exc_adel  = exc_q;
`else
  localparam logic [31:0] PC_RST = word_align(RESET_PC);

  assign pc_bad       = 1'b0;
  assign redirect_tgt = word_align(redirect_pc);
  assign adel_fire    = 1'b0;
`endif

  // Gated by reset so the port is quiet while reset is held even though the
  // state register already sits in FETCH.
  assign im_req  = !reset && (state_q == FETCH) && !pc_bad;
  assign im_addr = word_align(fetch_pc_q);

  assign req_fire    = im_req && im_gnt;
  // A response is usable only if it is ours, not flushed, and no redirect
  // is invalidating everything this cycle.
  assign rsp_live    = (state_q == WAIT) && im_rvalid && !discard_q && !redirect_valid;
  assign rsp_to_slot = rsp_live && !id_stall;
  assign rsp_to_buf  = rsp_live && id_stall;
  assign buf_to_slot = (state_q == HOLD) && buf_valid && !redirect_valid && !id_stall;
  assign buf_clear   = redirect_valid || buf_to_slot;

  if_skid_buf u_skid_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (rsp_to_buf),
    .clear_i (buf_clear),
    .instr_i (im_rdata),
    .pc_i    (req_pc_q),
    .valid_o (buf_valid),
    .instr_o (buf_instr),
    .pc_o    (buf_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= PC_RST;
      req_pc_q   <= '0;
      discard_q  <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_pc8_q   <= '0;
    end else begin
      // Redirect wins over a same-cycle grant: the granted response is
      // flagged for discard below.
      if (redirect_valid)  fetch_pc_q <= redirect_tgt;
      else if (req_fire)   fetch_pc_q <= fetch_pc_q + PC_INC4;
      if (req_fire)        req_pc_q   <= fetch_pc_q;

      case (state_q)
        FETCH: begin
          if (req_fire) begin
            state_q   <= WAIT;
            discard_q <= redirect_valid;
          end
        end
        WAIT: begin
          if (im_rvalid) begin
            state_q   <= rsp_to_buf ? HOLD : FETCH;
            discard_q <= 1'b0;
          end else if (redirect_valid) begin
            // Stay until the flushed response drains; one outstanding only.
            discard_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || !id_stall) state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase

      if (redirect_valid) begin
        id_valid_q <= 1'b0;
      end else if (rsp_to_slot) begin
        id_valid_q <= 1'b1;
        id_instr_q <= im_rdata;
        id_pc_q    <= req_pc_q;
        id_pc8_q   <= req_pc_q + PC_INC8;
      end else if (buf_to_slot) begin
        id_valid_q <= 1'b1;
        id_instr_q <= buf_instr;
        id_pc_q    <= buf_pc;
        id_pc8_q   <= buf_pc + PC_INC8;
      end else if (adel_fire) begin
        id_valid_q <= 1'b1;
        id_instr_q <= '0;
        id_pc_q    <= fetch_pc_q;
        id_pc8_q   <= fetch_pc_q + PC_INC8;
      end else if (!id_stall) begin
        id_valid_q <= 1'b0;
      end
    end
  end

`ifdef IF_ADEL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adel_sent_q <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      if (redirect_valid) adel_sent_q <= 1'b0;
      else if (adel_fire) adel_sent_q <= 1'b1;

      if (redirect_valid || rsp_to_slot || buf_to_slot) exc_q <= 1'b0;
      else if (adel_fire)                                exc_q <= 1'b1;
      else if (!id_stall)                                exc_q <= 1'b0;
    end
  end
`endif

  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;
  assign id_pc8   = id_pc8_q;

endmodule
